// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl: stall requests and
// exception request in, stall/flush vectors, PC redirect and watchdog status out.
interface pipe_ctrl_if #(
    parameter int STAGES = 6,
    parameter int CNT_W  = 8
);
    logic [STAGES-1:0] stallreq;
    logic              excp_req;
    logic [31:0]       excp_pc;
    logic              excp_ack;
    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] flush;
    logic              new_pc_valid;
    logic [31:0]       new_pc;
    logic [CNT_W-1:0]  stall_cnt;
    logic              timeout;

    // Pipeline side: raises requests, consumes control
    modport master (
        output stallreq, excp_req, excp_pc,
        input  excp_ack, stall, flush, new_pc_valid, new_pc, stall_cnt, timeout
    );

    // Controller side
    modport slave (
        input  stallreq, excp_req, excp_pc,
        output excp_ack, stall, flush, new_pc_valid, new_pc, stall_cnt, timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges per-stage stall requests, accepts exceptions into a
// one-cycle registered flush + PC redirect, and watches for frontend stall lock-up.
module pipe_ctrl #(
    parameter int STAGES     = 6,
    parameter int EXCP_STAGE = 4,
    parameter int CNT_W      = 8,
    parameter int MAX_STALL  = 255
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic {IDLE, FLUSH} state_t;

    function automatic logic [STAGES-1:0] low_mask(input int top);
        logic [STAGES-1:0] m;
        m = '0;
        for (int k = 0; k < STAGES; k++) begin
            m[k] = (k <= top);
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    localparam logic [STAGES-1:0] FLUSH_MASK = low_mask(EXCP_STAGE);
    localparam logic [CNT_W-1:0]  TO_PRE     = CNT_W'(MAX_STALL - 1);

    state_t            state;
    state_t            state_nxt;
    logic [STAGES-1:0] merge_p0;
    logic [STAGES-1:0] stall_p0;
    logic              upper_req_p0;
    logic              ack_p0;

    logic [STAGES-1:0] flush_p1;
    logic              new_pc_valid_p1;
    logic [31:0]       new_pc_p1;
    logic [CNT_W-1:0]  stall_cnt_p1;
    logic              timeout_p1;

    // Stage p0: a stalled stage holds every stage behind it (lower index)
    always_comb begin
        logic run;
        run      = 1'b0;
        merge_p0 = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            run         = run | bus.stallreq[j];
            merge_p0[j] = run;
        end
    end

    assign upper_req_p0 = |bus.stallreq[STAGES-1:EXCP_STAGE];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_p0  = '0;
        ack_p0    = 1'b0;
        case (state)
            IDLE: begin
                stall_p0 = merge_p0;
                ack_p0   = bus.excp_req & ~upper_req_p0;
                if (ack_p0) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
        endcase
        // Outputs stay quiet while reset is held so X inputs never propagate
        if (!rst) begin
            stall_p0 = '0;
            ack_p0   = 1'b0;
        end
    end

    // Stage p1: registered redirect and watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_p1        <= '0;
            new_pc_valid_p1 <= 1'b0;
            new_pc_p1       <= '0;
            stall_cnt_p1    <= '0;
            timeout_p1      <= 1'b0;
        end else begin
            flush_p1        <= ack_p0 ? FLUSH_MASK : '0;
            new_pc_valid_p1 <= ack_p0;
            if (ack_p0) begin
                new_pc_p1 <= bus.excp_pc;
            end
            stall_cnt_p1    <= stall_p0[0] ? sat_inc(stall_cnt_p1) : '0;
            // Only the MAX_STALL-1 -> MAX_STALL step fires; saturation never revisits it
            timeout_p1      <= stall_p0[0] && (stall_cnt_p1 == TO_PRE);
        end
    end

    assign bus.stall        = stall_p0;
    assign bus.excp_ack     = ack_p0;
    assign bus.flush        = flush_p1;
    assign bus.new_pc_valid = new_pc_valid_p1;
    assign bus.new_pc       = new_pc_p1;
    assign bus.stall_cnt    = stall_cnt_p1;
    assign bus.timeout      = timeout_p1;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model queues expected
// outputs per stimulus cycle; a negedge monitor pops and compares them.
module tb_pipe_ctrl;
    localparam int STAGES     = 6;
    localparam int EXCP_STAGE = 4;
    localparam int CNT_W      = 4;
    localparam int MAX_STALL  = 5;
    localparam int CNT_SAT    = 15;

    typedef struct packed {
        logic [5:0]  stall;
        logic [5:0]  flush;
        logic        ack;
        logic        npv;
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STAGES(STAGES), .CNT_W(CNT_W)) bus ();

    pipe_ctrl #(
        .STAGES(STAGES), .EXCP_STAGE(EXCP_STAGE), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model state
    bit          m_redirect = 0;
    logic [31:0] m_pc       = '0;
    int          m_cnt      = 0;
    bit          m_to       = 0;

    task automatic step(input logic r, input logic [5:0] sr, input logic er,
                        input logic [31:0] pc, output logic acked);
        exp_t        e;
        int          h;
        logic [5:0]  th;
        @(posedge clk);
        #1;
        rst          = r;
        bus.stallreq = sr;
        bus.excp_req = er;
        bus.excp_pc  = pc;
        e = '0;
        if (!r) begin
            m_redirect = 0;
            m_pc       = '0;
            m_cnt      = 0;
            m_to       = 0;
        end else begin
            h = -1;
            for (int k = 0; k < STAGES; k++) if (sr[k]) h = k;
            th      = (h < 0) ? 6'd0 : 6'((1 << (h + 1)) - 1);
            e.stall = m_redirect ? 6'd0 : th;
            e.flush = m_redirect ? 6'b011111 : 6'd0;
            e.ack   = !m_redirect && er && (sr[5:4] == 2'b00);
            e.npv   = m_redirect;
            e.pc    = m_pc;
            e.cnt   = 4'(m_cnt);
            e.to    = m_to;
            m_to    = e.stall[0] && (m_cnt == MAX_STALL - 1);
            m_cnt   = e.stall[0] ? ((m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT) : 0;
            if (e.ack) m_pc = pc;
            m_redirect = e.ack;
        end
        acked = e.ack;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("stall",        32'(bus.stall),        32'(e.stall));
                chk("flush",        32'(bus.flush),        32'(e.flush));
                chk("excp_ack",     32'(bus.excp_ack),     32'(e.ack));
                chk("new_pc_valid", 32'(bus.new_pc_valid), 32'(e.npv));
                chk("new_pc",       bus.new_pc,            e.pc);
                chk("stall_cnt",    32'(bus.stall_cnt),    32'(e.cnt));
                chk("timeout",      32'(bus.timeout),      32'(e.to));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        logic        a;
        logic [5:0]  sr;
        logic        pend;
        logic [31:0] ppc;
        rst          = 1'b0;
        bus.stallreq = '0;
        bus.excp_req = 1'b0;
        bus.excp_pc  = '0;

        repeat (3) step(1'b0, 6'd0, 1'b0, 32'd0, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);

        // Stall merge patterns
        step(1'b1, 6'b001000, 1'b0, 32'd0, a);
        step(1'b1, 6'b000101, 1'b0, 32'd0, a);
        step(1'b1, 6'b000000, 1'b0, 32'd0, a);

        // Plain acceptance
        step(1'b1, 6'd0, 1'b1, 32'hBFC00380, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);

        // Blocked by MEM stall, then accepted
        repeat (3) step(1'b1, 6'b010000, 1'b1, 32'h8000_1000, a);
        step(1'b1, 6'd0, 1'b1, 32'h8000_1000, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);

        // Request held through FLUSH is re-accepted two cycles later
        repeat (3) step(1'b1, 6'd0, 1'b1, 32'h8000_2000, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);

        // Lower-stage stall does not block; FLUSH overrides stall requests
        step(1'b1, 6'b001000, 1'b1, 32'h8000_3000, a);
        step(1'b1, 6'b001000, 1'b0, 32'd0, a);
        step(1'b1, 6'b000000, 1'b0, 32'd0, a);

        // Watchdog run and clear
        repeat (20) step(1'b1, 6'b000100, 1'b0, 32'd0, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);

        // Reset landing in FLUSH
        step(1'b1, 6'd0, 1'b1, 32'h8000_4000, a);
        step(1'b0, 6'd0, 1'b0, 32'd0, a);
        step(1'b0, 6'd0, 1'b0, 32'd0, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);

        // Randomised traffic with held exception requests and stall bursts
        sr   = '0;
        pend = 1'b0;
        ppc  = '0;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic r;
            sel = $urandom_range(0, 9);
            if (sel < 5)      sr = '0;
            else if (sel < 8) sr = 6'($urandom);
            if ((i % 200) == 100) begin
                logic [5:0] bsr;
                bsr = 6'($urandom_range(1, 15));
                for (int b = 0; b < int'($urandom_range(3, 20)); b++)
                    step(1'b1, bsr, 1'b0, 32'd0, a);
            end
            if (!pend && $urandom_range(0, 5) == 0) begin
                pend = 1'b1;
                ppc  = $urandom;
            end
            r = ($urandom_range(0, 199) != 0);
            step(r, sr, pend, ppc, a);
            if (a) pend = 1'b0;
        end
        step(1'b1, 6'd0, 1'b0, 32'd0, a);
        step(1'b1, 6'd0, 1'b0, 32'd0, a);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
